// File: rtl/pmem_arb_pkg.sv
// Shared types and line-geometry constants for the physical-memory arbiter.
package pmem_arb_pkg;

    // Line geometry shared with the cache parameters
    localparam int unsigned S_LINE_DEF   = 256;
    localparam int unsigned S_OFFSET_DEF = 5;
    localparam int unsigned ADDR_W       = 32;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RECOVER
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_e;

    // Width of a counter able to hold 0..limit
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/pmem_arb_select.sv
// Combinational winner selection between the I-cache and D-cache line requests.
module pmem_arb_select
    import pmem_arb_pkg::*;
#(
    parameter int unsigned ARB_MODE     = 1,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned STARVE_W     = 3
) (
    input  logic                i_req,
    input  logic                d_req,
    input  logic                last_grant,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                req_valid,
    output logic                winner
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // Pick the cache to serve next; a lone requester always wins
    always_comb begin
        req_valid = i_req | d_req;
        winner    = REQ_I;
        if (i_req && d_req) begin
            if (ARB_MODE == 1) begin
                // Round-robin: serve whoever was not served last
                winner = (last_grant == REQ_I) ? REQ_D : REQ_I;
            end else begin
                // Fixed D priority, but let I through once D has hogged the port
                winner = (starve_cnt == STARVE_MAX) ? REQ_I : REQ_D;
            end
        end else if (d_req) begin
            winner = REQ_D;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache.
// One transaction is latched at a time, driven until pmem_resp, answered to
// its owner only, then a one-cycle RECOVER lets the owner drop its request.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int unsigned S_LINE       = S_LINE_DEF,
    parameter int unsigned S_OFFSET     = S_OFFSET_DEF,
    parameter int unsigned ARB_MODE     = 1,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [S_LINE-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [S_LINE-1:0] d_pmem_wdata,
    output logic [S_LINE-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [S_LINE-1:0] pmem_wdata,
    input  logic [S_LINE-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  i_grant_count,
    output logic [CNT_W-1:0]  d_grant_count,
    output logic [CNT_W-1:0]  conflict_count
);

    localparam int unsigned         STARVE_W   = cnt_width(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0]   LINE_MASK  = ~((ADDR_W'(1) << S_OFFSET) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);

    arb_state_e          state_q;
    requester_e          last_grant_q;
    logic [STARVE_W-1:0] starve_cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [S_LINE-1:0]   wdata_q;
    logic                read_q;
    logic                write_q;
    logic [CNT_W-1:0]    i_grant_q;
    logic [CNT_W-1:0]    d_grant_q;
    logic [CNT_W-1:0]    conflict_q;

    logic i_req;
    logic d_req;
    logic req_valid;
    logic winner;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    pmem_arb_select #(
        .ARB_MODE     (ARB_MODE),
        .STARVE_LIMIT (STARVE_LIMIT),
        .STARVE_W     (STARVE_W)
    ) u_select (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .starve_cnt (starve_cnt_q),
        .req_valid  (req_valid),
        .winner     (winner)
    );

    // Arbitration FSM with latched transaction, registered strobes and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_I;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            i_grant_q    <= '0;
            d_grant_q    <= '0;
            conflict_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_req && d_req && conflict_q != '1) begin
                        conflict_q <= conflict_q + CNT_ONE;
                    end
                    if (req_valid) begin
                        if (winner == REQ_D) begin
                            state_q <= GRANT_D;
                            addr_q  <= d_pmem_address & LINE_MASK;
                            wdata_q <= d_pmem_wdata;
                            // Read+write together is illegal; the write-back wins
                            write_q <= d_pmem_write;
                            read_q  <= ~d_pmem_write;
                            if (i_req && starve_cnt_q != STARVE_MAX) begin
                                starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
                            end
                        end else begin
                            state_q      <= GRANT_I;
                            addr_q       <= i_pmem_address & LINE_MASK;
                            read_q       <= 1'b1;
                            write_q      <= 1'b0;
                            starve_cnt_q <= '0;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    // Strobe is held until the adaptor finishes, even if the
                    // requester has already let go
                    if (pmem_resp) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        state_q <= RECOVER;
                        if (state_q == GRANT_I) begin
                            last_grant_q <= REQ_I;
                            if (i_grant_q != '1) i_grant_q <= i_grant_q + CNT_ONE;
                        end else begin
                            last_grant_q <= REQ_D;
                            if (d_grant_q != '1) d_grant_q <= d_grant_q + CNT_ONE;
                        end
                    end
                end
                RECOVER: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // pmem side is driven purely from the latched transaction
    always_comb begin
        pmem_read    = read_q;
        pmem_write   = write_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
    end

    // Route the response and line data only to the cache that owns the grant
    always_comb begin
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_rdata = '0;
        if (state_q == GRANT_I) begin
            i_pmem_resp  = pmem_resp;
            i_pmem_rdata = pmem_rdata;
        end
        if (state_q == GRANT_D) begin
            d_pmem_resp  = pmem_resp;
            d_pmem_rdata = pmem_rdata;
        end
    end

    assign i_grant_count  = i_grant_q;
    assign d_grant_count  = d_grant_q;
    assign conflict_count = conflict_q;

    // D-cache must never read and write the same line at once
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(d_pmem_read && d_pmem_write));

    // Adaptor responses are only meaningful while a grant is outstanding
    a_resp_in_grant: assert property (@(posedge clk) disable iff (!rst)
        pmem_resp |-> (state_q == GRANT_I || state_q == GRANT_D));

    // Exactly one strobe is active for the whole grant
    a_one_strobe: assert property (@(posedge clk) disable iff (!rst)
        (state_q == GRANT_I || state_q == GRANT_D) |-> (pmem_read ^ pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench: two arbiters (round-robin, fixed-priority with 3-bit
// counters) share stimulus and a bench-side adaptor model.
module tb_pmem_arbiter;
    import pmem_arb_pkg::*;

    logic         clk = 1'b0;
    logic         rst_rr, rst_fp;
    logic         i_pmem_read, d_pmem_read, d_pmem_write;
    logic [31:0]  i_pmem_address, d_pmem_address;
    logic [255:0] d_pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    logic [255:0] rr_i_rdata, rr_d_rdata, rr_pmem_wdata;
    logic         rr_i_resp, rr_d_resp, rr_pmem_read, rr_pmem_write;
    logic [31:0]  rr_pmem_address;
    logic [23:0]  rr_i_cnt, rr_d_cnt, rr_c_cnt;

    logic [255:0] fp_i_rdata, fp_d_rdata, fp_pmem_wdata;
    logic         fp_i_resp, fp_d_resp, fp_pmem_read, fp_pmem_write;
    logic [31:0]  fp_pmem_address;
    logic [2:0]   fp_i_cnt, fp_d_cnt, fp_c_cnt;

    int tests = 0;
    int failed = 0;
    bit sel_fp = 1'b0;

    typedef struct {
        logic         who_d;
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] wdata;
    } exp_t;

    exp_t q_rr[$];
    exp_t q_fp[$];

    always #5 clk = ~clk;

    pmem_arbiter #(.ARB_MODE(1), .CNT_W(24)) u_rr (
        .clk(clk), .rst(rst_rr),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(rr_i_rdata), .i_pmem_resp(rr_i_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(rr_d_rdata), .d_pmem_resp(rr_d_resp),
        .pmem_read(rr_pmem_read), .pmem_write(rr_pmem_write),
        .pmem_address(rr_pmem_address), .pmem_wdata(rr_pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_grant_count(rr_i_cnt), .d_grant_count(rr_d_cnt), .conflict_count(rr_c_cnt)
    );

    pmem_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(4), .CNT_W(3)) u_fp (
        .clk(clk), .rst(rst_fp),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(fp_i_rdata), .i_pmem_resp(fp_i_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(fp_d_rdata), .d_pmem_resp(fp_d_resp),
        .pmem_read(fp_pmem_read), .pmem_write(fp_pmem_write),
        .pmem_address(fp_pmem_address), .pmem_wdata(fp_pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_grant_count(fp_i_cnt), .d_grant_count(fp_d_cnt), .conflict_count(fp_c_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_line(input string name, input logic [255:0] act,
                              input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit to_rr, input bit to_fp, input logic who_d,
                            input logic [31:0] addr, input logic wr, input logic [255:0] wdata);
        exp_t e;
        e.who_d = who_d;
        e.addr  = addr;
        e.wr    = wr;
        e.wdata = wdata;
        if (to_rr) q_rr.push_back(e);
        if (to_fp) q_fp.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait for a response on the currently observed arbiter
    task automatic wait_resp(output logic gi, output logic gd);
        gi = 1'b0;
        gd = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            gi = sel_fp ? fp_i_resp : rr_i_resp;
            gd = sel_fp ? fp_d_resp : rr_d_resp;
            if (gi || gd) return;
        end
        tests++;
        failed++;
        $display("FAIL resp_timeout: got no response, required one within 40 cycles");
    endtask

    // Scoreboard check of one response pulse
    task automatic mon(input bit is_fp, input logic ir, input logic dr, input logic rd,
                       input logic wr, input logic [31:0] addr, input logic [255:0] wdata,
                       input logic [255:0] irdata, input logic [255:0] drdata);
        exp_t  e;
        string p;
        p = is_fp ? "fp" : "rr";
        if (!(ir || dr)) return;
        if ((is_fp && q_fp.size() == 0) || (!is_fp && q_rr.size() == 0)) begin
            tests++;
            failed++;
            $display("FAIL %s_unexpected_resp: got i=%0b d=%0b, required no response", p, ir, dr);
            return;
        end
        if (is_fp) e = q_fp.pop_front();
        else       e = q_rr.pop_front();
        check({p, "_resp_route"}, 32'({ir, dr}), e.who_d ? 32'd1 : 32'd2);
        check({p, "_resp_addr"}, addr, e.addr);
        check({p, "_resp_strobe"}, 32'({rd, wr}), e.wr ? 32'd1 : 32'd2);
        if (e.wr) check_line({p, "_resp_wdata"}, wdata, e.wdata);
        check_line({p, "_owner_rdata"}, e.who_d ? drdata : irdata, pmem_rdata);
        check_line({p, "_other_rdata"}, e.who_d ? irdata : drdata, {256{1'b0}});
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_rr) mon(1'b0, rr_i_resp, rr_d_resp, rr_pmem_read, rr_pmem_write,
                        rr_pmem_address, rr_pmem_wdata, rr_i_rdata, rr_d_rdata);
        if (rst_fp) mon(1'b1, fp_i_resp, fp_d_resp, fp_pmem_read, fp_pmem_write,
                        fp_pmem_address, fp_pmem_wdata, fp_i_rdata, fp_d_rdata);
    end

    // Adaptor model: answer on the 5th cycle of an active strobe
    initial begin
        int busy;
        int idx;
        busy = 0;
        idx = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (rr_pmem_read | rr_pmem_write | fp_pmem_read | fp_pmem_write) begin
                busy++;
                if (busy == 5) begin
                    idx++;
                    pmem_resp = 1'b1;
                    pmem_rdata = {8{32'hC0DE_0000 | 32'(idx)}};
                    busy = 0;
                end
            end else begin
                busy = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200us");
        $fatal(1);
    end

    initial begin
        logic gi, gd;
        rst_rr = 1'b0;
        rst_fp = 1'b0;
        i_pmem_read = 1'b0;
        i_pmem_address = '0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata = '0;
        repeat (3) @(negedge clk);
        rst_rr = 1'b1;
        rst_fp = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_state", 32'(u_rr.state_q), 32'(IDLE));
        check("rst_strobes", 32'({rr_pmem_read, rr_pmem_write, fp_pmem_read, fp_pmem_write}), 0);
        check("rst_addr", rr_pmem_address, 0);
        check("rst_counts", 32'({rr_i_cnt, rr_d_cnt, rr_c_cnt}), 0);

        // 1: I read, strobe one cycle after the request is seen
        idle(1);
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_1000;
        push_exp(1, 1, 1'b0, 32'h0000_1000, 1'b0, '0);
        @(negedge clk);
        check("t1_no_strobe_cycle_n", 32'(rr_pmem_read), 0);
        @(negedge clk);
        check("t1_strobe_n1", 32'({rr_pmem_read, fp_pmem_read}), 32'h3);
        check("t1_addr", rr_pmem_address, 32'h0000_1000);
        wait_resp(gi, gd);
        check("t1_d_resp_low", 32'({gi, gd}), 32'h2);
        idle(1);
        i_pmem_read = 1'b0;
        @(negedge clk);
        check("t1_i_count", rr_i_cnt, 1);

        // 2: D write-back, latched address/data ignore live changes
        idle(2);
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_2040;
        d_pmem_wdata = {32{8'hA5}};
        push_exp(1, 1, 1'b1, 32'h0000_2040, 1'b1, {32{8'hA5}});
        repeat (2) @(negedge clk);
        check("t2_strobe", 32'({rr_pmem_read, rr_pmem_write}), 32'h1);
        idle(1);
        d_pmem_address = 32'hDEAD_BEE0;
        d_pmem_wdata = '0;
        @(negedge clk);
        check("t2_addr_held", rr_pmem_address, 32'h0000_2040);
        check_line("t2_wdata_held", rr_pmem_wdata, {32{8'hA5}});
        wait_resp(gi, gd);
        idle(1);
        d_pmem_write = 1'b0;
        @(negedge clk);
        check("t2_d_count", rr_d_cnt, 1);

        // 5: reset during a D write grant abandons it
        idle(2);
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_6000;
        d_pmem_wdata = {8{32'h1234_5678}};
        repeat (2) @(negedge clk);
        check("t5_write_active", 32'(rr_pmem_write), 1);
        #2;
        rst_rr = 1'b0;
        rst_fp = 1'b0;
        #1;
        check("t5_write_dropped", 32'({rr_pmem_write, fp_pmem_write}), 0);
        check("t5_state_idle", 32'(u_rr.state_q), 32'(IDLE));
        check("t5_counts_zero", 32'({rr_i_cnt, rr_d_cnt, rr_c_cnt}), 0);
        check("t5_resp_low", 32'({rr_d_resp, rr_i_resp}), 0);
        d_pmem_write = 1'b0;
        @(negedge clk);
        rst_rr = 1'b1;
        rst_fp = 1'b1;

        // 6: I drops its request mid-grant; strobe held, one response
        idle(2);
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_5000;
        push_exp(1, 1, 1'b0, 32'h0000_5000, 1'b0, '0);
        repeat (2) @(negedge clk);
        idle(1);
        i_pmem_read = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_strobe_held", 32'({rr_pmem_read, fp_pmem_read}), 32'h3);
        wait_resp(gi, gd);
        check("t6_i_resp", 32'({gi, gd}), 32'h2);
        @(negedge clk);
        check("t6_recover", 32'(u_rr.state_q), 32'(RECOVER));
        check("t6_recover_no_strobe", 32'(rr_pmem_read), 0);
        @(negedge clk);
        check("t6_idle", 32'(u_rr.state_q), 32'(IDLE));
        check("t6_i_count", rr_i_cnt, 1);

        // 3: simultaneous requests, last grant was I: D then I
        idle(2);
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_3000;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_4000;
        push_exp(1, 1, 1'b1, 32'h0000_4000, 1'b0, '0);
        push_exp(1, 1, 1'b0, 32'h0000_3000, 1'b0, '0);
        wait_resp(gi, gd);
        check("t3_d_first", 32'({gi, gd}), 32'h1);
        idle(1);
        d_pmem_read = 1'b0;
        @(negedge clk);
        check("t3_gap_recover", 32'(rr_pmem_read), 0);
        @(negedge clk);
        check("t3_gap_idle", 32'(rr_pmem_read), 0);
        @(negedge clk);
        check("t3_i_strobe", 32'(rr_pmem_read), 1);
        check("t3_i_addr", rr_pmem_address, 32'h0000_3000);
        wait_resp(gi, gd);
        check("t3_i_second", 32'({gi, gd}), 32'h2);
        idle(1);
        i_pmem_read = 1'b0;
        @(negedge clk);
        check("t3_conflict_rr", rr_c_cnt, 1);
        check("t3_conflict_fp", 32'(fp_c_cnt), 1);
        check("t3_counts", 32'({rr_i_cnt[7:0], rr_d_cnt[7:0]}), 32'h0201);

        // 4: fixed priority starvation limit; round-robin arbiter held in reset
        idle(1);
        rst_rr = 1'b0;
        rst_fp = 1'b0;
        sel_fp = 1'b1;
        @(negedge clk);
        rst_fp = 1'b1;
        idle(2);
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_7000;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_8000;
        begin
            int d_idx;
            d_idx = 0;
            for (int g = 0; g < 9; g++) begin
                if (g == 4) push_exp(0, 1, 1'b0, 32'h0000_7000, 1'b0, '0);
                else push_exp(0, 1, 1'b1, 32'h0000_8000 + 32'(d_idx) * 32'h20, 1'b0, '0);
                wait_resp(gi, gd);
                check($sformatf("t4_grant_%0d", g), 32'({gi, gd}), (g == 4) ? 32'h2 : 32'h1);
                idle(1);
                if (gd) begin
                    d_idx++;
                    d_pmem_address = 32'h0000_8000 + 32'(d_idx) * 32'h20;
                end
                if (gi) i_pmem_read = 1'b0;
            end
        end
        d_pmem_read = 1'b0;
        @(negedge clk);
        check("t4_i_count", 32'(fp_i_cnt), 1);
        check("t4_d_count_sat", 32'(fp_d_cnt), 7);
        check("t4_conflicts", 32'(fp_c_cnt), 5);
        check("t4_rr_quiet", 32'({rr_pmem_read, rr_i_resp, rr_d_resp}), 0);

        idle(3);
        check("end_rr_queue_empty", 32'(q_rr.size()), 0);
        check("end_fp_queue_empty", 32'(q_fp.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
Shares one physical-memory line port between the instruction cache and the data cache, which both issue 256-bit line reads and write-backs. It latches one requester's line transaction, drives it onto pmem until pmem_resp, routes the response back to that requester only, then re-arbitrates. It sits between the two cache_control/datapath pairs and the cacheline adaptor.

Parameters:
S_LINE, 256, line width in bits (matches cache s_line)
S_OFFSET, 5, byte-offset bits; line addresses have low S_OFFSET bits zero
ARB_MODE, 1, 0 = fixed data-cache priority, 1 = round-robin between the two caches
STARVE_LIMIT, 4, max consecutive D grants while I is pending (ARB_MODE=0 only)
CNT_W, 24, grant/stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
i_pmem_read  in  1  I-cache line read request
i_pmem_address  in  32  I-cache line address
i_pmem_rdata  out  S_LINE  line data to I-cache
i_pmem_resp  out  1  I-cache transaction done
d_pmem_read  in  1  D-cache line read request
d_pmem_write  in  1  D-cache line write-back request
d_pmem_address  in  32  D-cache line address
d_pmem_wdata  in  S_LINE  D-cache write-back data
d_pmem_rdata  out  S_LINE  line data to D-cache
d_pmem_resp  out  1  D-cache transaction done
pmem_read  out  1  read to adaptor
pmem_write  out  1  write to adaptor
pmem_address  out  32  line address to adaptor
pmem_wdata  out  S_LINE  write data to adaptor
pmem_rdata  in  S_LINE  read data from adaptor
pmem_resp  in  1  adaptor transaction done
i_grant_count  out  CNT_W  completed I transactions
d_grant_count  out  CNT_W  completed D transactions
conflict_count  out  CNT_W  cycles in IDLE with both requesters pending

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RECOVER. Reset value: IDLE. All outputs and counters are 0, last_grant = I, starve_cnt = 0, and latched address/data/op are 0.
- IDLE: the winner is evaluated from the live requests. The address is latched, plus wdata and op (read/write) for D. The next state is the matching GRANT_x. With no request, stay in IDLE.
- Winner selection when both are pending:
  - ARB_MODE=1: grant the cache not in last_grant.
  - ARB_MODE=0: grant D unless starve_cnt == STARVE_LIMIT, in which case grant I.
  - A single pending requester always wins.
- starve_cnt: increments on each D grant while I is pending, clears on any I grant, and saturates at STARVE_LIMIT.
- GRANT_x:
  - pmem_read/pmem_write, pmem_address and pmem_wdata are driven from the latched registers, not the live inputs.
  - Latency: request seen in IDLE at cycle N, pmem strobe high from cycle N+1.
- Response routing:
  - x_pmem_resp = pmem_resp, combinational, in the same cycle, only in GRANT_x. The other requester's resp stays 0.
  - x_pmem_rdata = pmem_rdata while in GRANT_x, otherwise 0.
- On pmem_resp: increment the matching grant counter, update last_grant, and go to RECOVER.
- RECOVER: lasts one cycle, with no strobes and requests ignored, so the finished cache can drop its request. Then go to IDLE. Back-to-back grants are therefore separated by 2 idle pmem cycles (RECOVER, IDLE).
- D with read and write both high is a protocol violation. Write wins, and an assertion fires in simulation.
- Requester deasserting mid-grant: the pmem strobe is held until pmem_resp (the adaptor cannot abort). The response is still pulsed to that requester.
- pmem_resp outside a GRANT state: ignored, and an assertion fires.
- Counters: saturate at all-ones and do not wrap.
- conflict_count: increments in IDLE when i_pmem_read and (d_pmem_read or d_pmem_write) are both high.
- Reset asserted mid-transaction:
  - Strobes and resps drop asynchronously.
  - The state returns to IDLE and the in-flight transaction is abandoned.
  - The adaptor shares the reset.

Decomposition:
- Shared package pmem_arb_pkg holds:
  - the arb_state_e enum (IDLE, GRANT_I, GRANT_D, RECOVER);
  - the requester_e enum (REQ_I, REQ_D);
  - line-width constants shared with the cache parameters.
- One natural sub-module, pmem_arb_select: combinational winner selection from the requests, last_grant, starve_cnt and ARB_MODE.
- The FSM, latches, routing and counters stay in the top module.

Test Plan:
1. I-read only at 0x0000_1000, with pmem_resp after 5 cycles:
   - pmem_read=1 and address 0x1000 from N+1;
   - i_pmem_resp pulses with pmem_resp, d_pmem_resp stays 0;
   - i_grant_count=1.
2. D write-back at 0x0000_2040 with wdata 256'hA5…:
   - pmem_write=1, pmem_wdata latched;
   - d_pmem_address changing mid-grant does not alter pmem_address.
3. I and D asserted in the same IDLE cycle, ARB_MODE=1, last_grant=I:
   - D is served first;
   - then, after RECOVER, I is served;
   - conflict_count ≥ 1.
4. ARB_MODE=0, STARVE_LIMIT=4, D re-requesting continuously, I pending: the 5th grant goes to I.
5. Reset asserted while in GRANT_D with pmem_write high: pmem_write drops immediately, the state is IDLE, and the counters are 0.
6. I deasserts i_pmem_read during GRANT_I: pmem_read is held until pmem_resp, i_pmem_resp pulses once, and the FSM returns via RECOVER to IDLE.
